// File: rtl/cfgtag_gw_pkg.sv
// Shared types, header layout and helpers for the multi-channel config-tag gateway.
package cfgtag_gw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY
  } state_e;

  localparam int HDR_CHAN_LSB = 28;
  localparam int HDR_CHAN_W   = 4;
  localparam int HDR_CNT_LSB  = 20;
  localparam int HDR_CNT_W    = 8;
  localparam int HDR_ID_LSB   = 0;
  localparam int HDR_ID_W     = 20;

  function automatic int cfgtag_gw_words_f(input int bits);
    return (bits + 31) / 32;
  endfunction

endpackage

// File: rtl/cfgtag_gw_chan.sv
// Per-channel capture: detects a new packet by ID change and holds it until the arbiter selects it.
module cfgtag_gw_chan
  import cfgtag_gw_pkg::*;
#(
  parameter int ID_W  = 4,
  parameter int PAY_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  select_i,
  input  logic [ID_W+PAY_W-1:0] slice_i,
  output logic                  pend_o,
  output logic [PAY_W-1:0]      data_o,
  output logic [ID_W-1:0]       id_o,
  output logic                  overrun_o
);

  logic [ID_W-1:0]  id_in;
  logic [PAY_W-1:0] pay_in;
  logic             new_pkt;

  logic [ID_W-1:0]  last_id_q, last_id_d;
  logic             pend_q, pend_d;
  logic [PAY_W-1:0] pend_data_q, pend_data_d;
  logic             overrun_q, overrun_d;

  assign id_in   = slice_i[ID_W+PAY_W-1 -: ID_W];
  assign pay_in  = slice_i[PAY_W-1:0];
  assign new_pkt = (id_in != last_id_q) && (id_in != '0);

  // A new packet arriving in the selection cycle re-arms pend; the old one leaves via data_o.
  always_comb begin
    last_id_d   = last_id_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    overrun_d   = overrun_q;
    if (select_i) begin
      pend_d = 1'b0;
    end
    if (new_pkt) begin
      last_id_d   = id_in;
      pend_data_d = pay_in;
      pend_d      = 1'b1;
      if (pend_q && !select_i) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_id_q   <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      last_id_q   <= last_id_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      overrun_q   <= overrun_d;
    end
  end

  // last_id always tracks the held packet, so it doubles as the pending ID.
  assign pend_o    = pend_q;
  assign data_o    = pend_data_q;
  assign id_o      = last_id_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/cfgtag_gw_multi.sv
// Multi-channel config-tag gateway: round-robin arbitration over channels, header+payload
// serialisation onto a 32-bit raw network link with credit flow control.
module cfgtag_gw_multi
  import cfgtag_gw_pkg::*;
#(
  parameter int channels_p        = 4,
  parameter int packet_ID_width_p = 4,
  parameter int payload_width_p   = 32,
  parameter int credits_p         = 4
) (
  input  logic                                                     clk,
  input  logic                                                     reset_n,
  input  logic [channels_p*(packet_ID_width_p+payload_width_p)-1:0] cfgtag_data_i,
  input  logic                                                     credit_i,
  output logic                                                     valid_o,
  output logic [31:0]                                              data_o,
  output logic [channels_p-1:0]                                    overrun_o
);

  localparam int SLICE_W = packet_ID_width_p + payload_width_p;
  localparam int WORDS   = cfgtag_gw_words_f(payload_width_p);
  localparam int CNT_W   = $clog2(credits_p + 1);
  localparam int CH_W    = (channels_p > 1) ? $clog2(channels_p) : 1;
  localparam int IDX_W   = HDR_CNT_W;

  logic [channels_p-1:0]        pend;
  logic [channels_p-1:0]        select;
  logic [payload_width_p-1:0]   ch_data [channels_p];
  logic [packet_ID_width_p-1:0] ch_id   [channels_p];

  generate
    for (genvar gi = 0; gi < channels_p; gi++) begin : g_chan
      cfgtag_gw_chan #(
        .ID_W  (packet_ID_width_p),
        .PAY_W (payload_width_p)
      ) u_chan (
        .clk       (clk),
        .reset_n   (reset_n),
        .select_i  (select[gi]),
        .slice_i   (cfgtag_data_i[gi*SLICE_W +: SLICE_W]),
        .pend_o    (pend[gi]),
        .data_o    (ch_data[gi]),
        .id_o      (ch_id[gi]),
        .overrun_o (overrun_o[gi])
      );
    end
  endgenerate

  state_e                       state_q, state_d;
  logic [CH_W-1:0]              last_q, last_d;
  logic [CH_W-1:0]              chan_q, chan_d;
  logic [packet_ID_width_p-1:0] id_q, id_d;
  logic [payload_width_p-1:0]   sdata_q, sdata_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  logic            send;
  logic            found, found_hi, found_lo;
  logic [CH_W-1:0] grant, grant_hi, grant_lo;
  logic [WORDS*32-1:0] padded;
  logic [31:0]     hdr;

  assign send    = (state_q != ST_IDLE) && (cnt_q != '0);
  assign valid_o = send;

  // Round robin: lowest pending channel above last-served wins, else lowest at or below it.
  always_comb begin
    grant_hi = '0;
    grant_lo = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int c = channels_p - 1; c >= 0; c--) begin
      if (pend[c]) begin
        if (c > int'(last_q)) begin
          found_hi = 1'b1;
          grant_hi = CH_W'(c);
        end else begin
          found_lo = 1'b1;
          grant_lo = CH_W'(c);
        end
      end
    end
    found = found_hi | found_lo;
    grant = found_hi ? grant_hi : grant_lo;
  end

  assign select = (state_q == ST_IDLE && found) ? (channels_p'(1) << grant) : '0;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    chan_d  = chan_q;
    id_d    = id_q;
    sdata_d = sdata_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          last_d  = grant;
          chan_d  = grant;
          id_d    = ch_id[grant];
          sdata_d = ch_data[grant];
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (send) begin
          idx_d   = '0;
          state_d = ST_PAY;
        end
      end
      ST_PAY: begin
        if (send) begin
          if (idx_q == IDX_W'(WORDS - 1)) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cnt_d = cnt_q;
    if (send && !credit_i) begin
      cnt_d = cnt_q - 1'b1;
    end else if (credit_i && !send && cnt_q != CNT_W'(credits_p)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    padded                      = '0;
    padded[payload_width_p-1:0] = sdata_q;
    hdr                                = '0;
    hdr[HDR_CHAN_LSB +: HDR_CHAN_W]    = HDR_CHAN_W'(chan_q);
    hdr[HDR_CNT_LSB +: HDR_CNT_W]      = HDR_CNT_W'(WORDS);
    hdr[HDR_ID_LSB +: HDR_ID_W]        = HDR_ID_W'(id_q);
    unique case (state_q)
      ST_HDR:  data_o = hdr;
      ST_PAY:  data_o = padded[32*idx_q +: 32];
      default: data_o = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= CH_W'(channels_p - 1);
      chan_q  <= '0;
      id_q    <= '0;
      sdata_q <= '0;
      idx_q   <= '0;
      cnt_q   <= CNT_W'(credits_p);
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      chan_q  <= chan_d;
      id_q    <= id_d;
      sdata_q <= sdata_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  credit_overflow_a: assert property (@(posedge clk) disable iff (!reset_n)
    !(credit_i && !send && cnt_q == CNT_W'(credits_p)));

endmodule

// File: doc/cfgtag_gw_multi.md
# cfgtag_gw_multi

Multi-channel successor to the single-channel config-tag gateway. Watches `channels_p` config_node outputs in the `clk` domain. Detects each newly delivered packet by a change of its packet-ID field. Serialises the packet as a header word plus zero-padded 32-bit payload words onto the raw network, with credit-based flow control and round-robin fairness between channels.

## Interface
- `channels_p`, 4: number of config_node inputs (1..16).
- `packet_ID_width_p`, 4: ID field width per channel (1..20); ID is the MSBs of each channel slice.
- `payload_width_p`, 32: payload bits per channel (1..255*32).
- `credits_p`, 4: output credits available after reset (1..255).
- `clk`  in  1  destination-side clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cfgtag_data_i`  in  `channels_p*(packet_ID_width_p+payload_width_p)`  channel c occupies slice c; within a slice, {id, payload}.
- `credit_i`  in  1  one credit returned per cycle asserted.
- `valid_o`  out  1  word on `data_o` is sent this cycle.
- `data_o`  out  32  header or payload word.
- `overrun_o`  out  `channels_p`  sticky per-channel overrun flag.

## Operation
- `words_lp = ceil(payload_width_p/32)`; last payload word zero-padded in its MSBs.
- **Per-channel capture**
  - `last_id[c]` resets to 0; ID 0 is reserved (idle/default).
  - New packet on c when `id != last_id[c]` and `id != 0`.
  - On a new packet: update `last_id[c]`, load `pend_data[c]`, set `pend[c]`.
  - If `pend[c]` is already set and the channel is not being selected that cycle: overwrite the data and set `overrun_o[c]`, which stays set until reset.
- **FSM: IDLE, HDR, PAY.**
  - IDLE:
    - If any `pend`, pick a channel by round-robin starting after the last-served channel; after reset the search starts at channel 0.
    - Copy its data and ID into the send register, clear its `pend`, go to HDR.
  - HDR: drive the header; on send, go to PAY with `idx=0`.
  - PAY: drive payload word `idx`, LSW first; on send, `idx++`; after word `words_lp-1` is sent, go to IDLE.
- **Simultaneous new packet and selection on the same channel:** the send register takes the old data, and `pend` stays set with the new data. This is not an overrun.
- **Header format:** [31:28] channel index, [27:20] `words_lp`, [19:0] packet ID zero-extended.
- **Credit counter**, width `$clog2(credits_p+1)`, reset value `credits_p`:
  - `-1` on a send, `+1` on `credit_i`; both in the same cycle leaves it unchanged.
  - `credit_i` while the counter is at `credits_p` saturates the counter and fires a simulation assertion.
- **Send condition:** `valid_o = (state != IDLE) && (cnt != 0)`.

## Timing
- **Reset values:** `valid_o=0`, `data_o=0`, `overrun_o=0`, state IDLE, `cnt=credits_p`, all `pend=0`, `last_id=0`.
- **`data_o` in IDLE:** 0.
- **Latency:** ID change sampled at edge t sets `pend`; selection at edge t+1; header `valid_o` during cycle t+1..t+2 (2 cycles input-to-header) when credit is available.
- **Throughput:** one word per cycle while credits last; one IDLE bubble cycle between packets.
- **Credit timing:** `credit_i` is usable the cycle after it is asserted, never combinationally.
- **Reset mid-packet:** abandon the packet immediately. No partial resume.

## Structure
- Shared package `cfgtag_gw_pkg`:
  - `state_e` enum;
  - header field offsets and widths (chan, count, id);
  - `cfgtag_gw_words_f` function (ceil division).
- Sub-module `cfgtag_gw_chan`: one instance per channel. Holds `last_id`, `pend`, `pend_data` and `overrun`. Its inputs are `select_i` and the slice; its outputs are `pend_o`, `data_o` and `id_o`.
- The top holds the round-robin arbiter (`bsg_arb_round_robin` style), FSM, credit counter and output mux.

## Test plan
- **Single packet:** `channels_p=4`, `payload_width_p=40`, `credits_p=4`. Channel 2 ID 0→3 with payload 40'hAB_1234_5678.
  - Expect 3 words: 32'h2_02_00003, 32'h12345678, 32'h000000AB.
  - `valid_o` rises 2 cycles after the ID change.
- **Credit stall:** `credits_p=2`, no `credit_i`. Exactly 2 words are sent, then `valid_o=0`. A single `credit_i` pulse releases exactly one more word the next cycle.
- **Round robin:** channels 0, 1 and 3 change ID in the same cycle. Packets emerge in order 0, 1, 3. A later repeat on 0 and 3, with last-served 3, yields order 0, 3.
- **Overrun:** channel 1 gets ID 1, then ID 2 while its packet is still pending behind a stalled transmission. Expect `overrun_o[1]=1` and only ID 2's packet sent. Other overrun bits stay 0.
- **Same-cycle select and new ID:** a new ID on a channel in its selection cycle. Expect the old packet sent, followed by the new packet, with no overrun flag.
- **Async reset mid-payload:** assert `reset_n=0` between clock edges. `valid_o` drops immediately and the counter returns to `credits_p`. After release, ID 0 on any channel produces no traffic.
